prbs_pattern_gen: RTL and testbench

//  Parametrised successor of the fixed 8-bit PRBS block: plays a loaded pattern N times, then

---
 rtl/prbs_pattern_gen.sv | 171 +++++++++++++++++
 tb/tb_prbs_pattern_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_pattern_gen.sv
// Test-pattern source: replays a loaded pattern n times, then streams Fibonacci LFSR data.
// Optional macro PRBS_ERR_INJ_EN adds a one-shot bit-0 error injection on random beats.
module prbs_pattern_gen #(
    parameter int                DATA_W    = 8,
    parameter int                PAT_BEATS = 4,
    parameter int                LFSR_W    = 15,
    parameter logic [LFSR_W-1:0] TAPS      = 15'h6000,
    parameter int                CNT_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_valid,
    input  logic [DATA_W*PAT_BEATS-1:0]   in,
    input  logic [CNT_W-1:0]              n,
    input  logic                          stop,
    input  logic                          out_ready,
`ifdef PRBS_ERR_INJ_EN
    input  logic                          err_inj,
`endif
    output logic [DATA_W-1:0]             prbs_out,
    output logic                          out_valid,
    output logic                          rand_flag,
    output logic                          seq_done,
    output logic                          busy
);

    localparam int IDX_W = (PAT_BEATS > 1) ? $clog2(PAT_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, SEQ, RAND} state_t;

    state_t                        state, state_d;
    logic [DATA_W*PAT_BEATS-1:0]   pat_r, pat_d;
    logic [CNT_W-1:0]              n_r, n_d;
    logic [CNT_W-1:0]              rep_cnt, rep_d;
    logic [IDX_W-1:0]              beat_idx, idx_d;
    logic [LFSR_W-1:0]             lfsr, lfsr_d;
    logic [DATA_W-1:0]             data_r, data_d;

    logic [LFSR_W-1:0]             seed;
    logic [LFSR_W-1:0]             lfsr_step;
    logic                          accept;
    logic                          last_beat;
    logic                          last_rep;

`ifdef PRBS_ERR_INJ_EN
    logic                          err_armed, err_armed_d;
    logic                          inj;
`endif

    // Beat i of the pattern, most-significant beat first.
    function automatic logic [DATA_W-1:0] beat_of(input logic [DATA_W*PAT_BEATS-1:0] p,
                                                  input logic [IDX_W-1:0] i);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < PAT_BEATS; b++) begin
            if (IDX_W'(b) == i) r = p[DATA_W*(PAT_BEATS-1-b) +: DATA_W];
        end
        return r;
    endfunction

    assign accept    = out_valid & out_ready;
    assign last_beat = (beat_idx == IDX_W'(PAT_BEATS-1));
    assign last_rep  = (rep_cnt == n_r - CNT_W'(1));
    assign seed      = (in[LFSR_W-1:0] == '0) ? '1 : in[LFSR_W-1:0];
    assign lfsr_step = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};

    always_comb begin
        state_d = state;
        pat_d   = pat_r;
        n_d     = n_r;
        rep_d   = rep_cnt;
        idx_d   = beat_idx;
        lfsr_d  = lfsr;
        data_d  = data_r;
`ifdef PRBS_ERR_INJ_EN
        err_armed_d = 1'b0;
        inj         = 1'b0;
`endif
        // A load is honoured from IDLE and from RAND; SEQ runs to completion.
        if (data_valid && (state == IDLE || state == RAND)) begin
            pat_d  = in;
            n_d    = n;
            rep_d  = '0;
            idx_d  = '0;
            lfsr_d = seed;
            if (n != '0) begin
                state_d = SEQ;
                data_d  = in[DATA_W*PAT_BEATS-1 -: DATA_W];
            end else begin
                state_d = RAND;
                data_d  = seed[DATA_W-1:0];
            end
        end else begin
            case (state)
                SEQ: begin
                    if (accept) begin
                        if (last_beat) begin
                            idx_d = '0;
                            if (last_rep) begin
                                state_d = RAND;
                                data_d  = lfsr[DATA_W-1:0];
                            end else begin
                                rep_d  = rep_cnt + CNT_W'(1);
                                data_d = beat_of(pat_r, '0);
                            end
                        end else begin
                            idx_d  = beat_idx + IDX_W'(1);
                            data_d = beat_of(pat_r, beat_idx + IDX_W'(1));
                        end
                    end
                end
                RAND: begin
                    if (stop) begin
                        state_d = IDLE;
                    end else begin
`ifdef PRBS_ERR_INJ_EN
                        err_armed_d = err_armed | err_inj;
                        if (accept) begin
                            inj         = err_armed | err_inj;
                            err_armed_d = 1'b0;
                        end
`endif
                        if (accept) begin
                            lfsr_d = lfsr_step;
`ifdef PRBS_ERR_INJ_EN
                            data_d = lfsr_step[DATA_W-1:0] ^ {{(DATA_W-1){1'b0}}, inj};
`else
                            data_d = lfsr_step[DATA_W-1:0];
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pat_r    <= '0;
            n_r      <= '0;
            rep_cnt  <= '0;
            beat_idx <= '0;
            lfsr     <= '1;
            data_r   <= '0;
        end else begin
            state    <= state_d;
            pat_r    <= pat_d;
            n_r      <= n_d;
            rep_cnt  <= rep_d;
            beat_idx <= idx_d;
            lfsr     <= lfsr_d;
            data_r   <= data_d;
        end
    end

`ifdef PRBS_ERR_INJ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_armed <= 1'b0;
        else     err_armed <= err_armed_d;
    end
`endif

    assign prbs_out  = data_r;
    assign out_valid = (state != IDLE);
    assign busy      = (state != IDLE);
    assign rand_flag = (state == RAND);
    assign seq_done  = (state == SEQ) & accept & last_beat & last_rep;

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Self-checking bench for prbs_pattern_gen against a queue-based beat model.
module tb_prbs_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic [31:0] in_pat;
    logic [7:0]  n;
    logic        stop;
    logic        out_ready;
`ifdef PRBS_ERR_INJ_EN
    logic        err_inj;
`endif
    logic [7:0]  prbs_out;
    logic        out_valid;
    logic        rand_flag;
    logic        seq_done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    prbs_pattern_gen #(
        .DATA_W(8), .PAT_BEATS(4), .LFSR_W(15), .TAPS(15'h6000), .CNT_W(8)
    ) dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .in(in_pat), .n(n),
        .stop(stop), .out_ready(out_ready),
`ifdef PRBS_ERR_INJ_EN
        .err_inj(err_inj),
`endif
        .prbs_out(prbs_out), .out_valid(out_valid), .rand_flag(rand_flag),
        .seq_done(seq_done), .busy(busy)
    );

    // Expected beats: nrep copies of the pattern (MS byte first), then nrand LFSR beats.
    function automatic int lfsr_next(input int s);
        return ((s << 1) & 32'h7FFF) | ($countones(s & 32'h6000) % 2);
    endfunction

    function automatic void build_model(input logic [31:0] pat, input int nrep, input int nrand);
        int s;
        exp_q.delete();
        for (int r = 0; r < nrep; r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((pat >> (8 * (3 - b))) & 32'hFF));
        s = int'(pat[14:0]);
        if (s == 0) s = 32'h7FFF;
        for (int i = 0; i < nrand; i++) begin
            exp_q.push_back(8'(s));
            s = lfsr_next(s);
        end
    endfunction

    task automatic load(input logic [31:0] p, input logic [7:0] nn);
        @(negedge clk);
        data_valid = 1'b1;
        in_pat     = p;
        n          = nn;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; data_valid = 1'b0; in_pat = '0; n = '0; stop = 1'b0; out_ready = 1'b0;
`ifdef PRBS_ERR_INJ_EN
        err_inj = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_checks++; if (prbs_out !== 8'h00) begin n_fail++; $display("FAIL reset_prbs_out got %h expected 00", prbs_out); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        n_checks++; if (rand_flag !== 1'b0) begin n_fail++; $display("FAIL reset_rand_flag got %b expected 0", rand_flag); end
        n_checks++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL reset_seq_done got %b expected 0", seq_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_out_valid got %b expected 0", out_valid); end
    endtask

    task automatic test_pattern;
        logic [31:0] p;
        int nr;
        for (int t = 0; t < 5; t++) begin
            p  = (t == 0) ? 32'hDEADBEEF : $urandom;
            nr = (t == 0) ? 2 : $urandom_range(1, 3);
            build_model(p, nr, 6);
            out_ready = 1'b1;
            load(p, 8'(nr));
            for (int i = 0; i < exp_q.size(); i++) begin
                #1;
                n_checks++; if (prbs_out !== exp_q[i]) begin n_fail++; $display("FAIL pattern_data t%0d beat %0d got %h expected %h", t, i, prbs_out, exp_q[i]); end
                n_checks++; if (rand_flag !== (i >= nr * 4)) begin n_fail++; $display("FAIL pattern_rand_flag t%0d beat %0d got %b", t, i, rand_flag); end
                n_checks++; if (seq_done !== (i == nr * 4 - 1)) begin n_fail++; $display("FAIL pattern_seq_done t%0d beat %0d got %b", t, i, seq_done); end
                n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL pattern_valid_busy t%0d beat %0d got %b%b expected 11", t, i, out_valid, busy); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_n_zero;
        logic [31:0] p;
        for (int t = 0; t < 4; t++) begin
            p = (t == 0) ? 32'h00000001 : $urandom;
            build_model(p, 0, 12);
            out_ready = 1'b1;
            load(p, 8'd0);
            for (int i = 0; i < exp_q.size(); i++) begin
                #1;
                n_checks++; if (prbs_out !== exp_q[i]) begin n_fail++; $display("FAIL nzero_data t%0d beat %0d got %h expected %h", t, i, prbs_out, exp_q[i]); end
                n_checks++; if (rand_flag !== 1'b1 || seq_done !== 1'b0) begin n_fail++; $display("FAIL nzero_flags t%0d beat %0d got rf=%b sd=%b expected rf=1 sd=0", t, i, rand_flag, seq_done); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_period;
        int s;
        int bad;
        out_ready = 1'b1;
        load(32'h0, 8'd0);
        #1;
        n_checks++; if (prbs_out !== 8'hFF) begin n_fail++; $display("FAIL zero_seed_first got %h expected ff", prbs_out); end
        s = 32'h7FFF;
        bad = 0;
        for (int k = 1; k <= 32767; k++) begin
            @(negedge clk);
            #1;
            s = lfsr_next(s);
            if (prbs_out !== 8'(s)) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL period_sequence got %0d wrong beats expected 0", bad); end
        n_checks++; if (prbs_out !== 8'hFF) begin n_fail++; $display("FAIL period_wrap got %h expected ff", prbs_out); end
    endtask

    task automatic test_backpressure;
        int idx;
        int done_cycle;
        logic [31:0] p;
        int nr;
        build_model(32'hDEADBEEF, 2, 4);
        out_ready = 1'b0;
        load(32'hDEADBEEF, 8'd2);
        idx = 0;
        done_cycle = -1;
        for (int c = 0; c < 40 && idx < exp_q.size(); c++) begin
            out_ready = ((c % 2) == 1);
            #1;
            n_checks++; if (prbs_out !== exp_q[idx] || out_valid !== 1'b1) begin n_fail++; $display("FAIL toggle_data cycle %0d got %h/%b expected %h/1", c, prbs_out, out_valid, exp_q[idx]); end
            n_checks++; if (seq_done !== (out_ready && idx == 7)) begin n_fail++; $display("FAIL toggle_seq_done cycle %0d got %b", c, seq_done); end
            if (seq_done === 1'b1) done_cycle = c;
            if (out_ready) idx++;
            @(negedge clk);
        end
        n_checks++; if (idx !== exp_q.size()) begin n_fail++; $display("FAIL toggle_timeout got %0d beats expected %0d", idx, exp_q.size()); end
        n_checks++; if (done_cycle !== 15) begin n_fail++; $display("FAIL toggle_duration got seq_done at cycle %0d expected 15", done_cycle); end

        for (int t = 0; t < 3; t++) begin
            p  = $urandom;
            nr = $urandom_range(1, 2);
            build_model(p, nr, 5);
            load(p, 8'(nr));
            idx = 0;
            for (int c = 0; c < 200 && idx < exp_q.size(); c++) begin
                out_ready = ($urandom_range(0, 2) != 0);
                #1;
                n_checks++; if (prbs_out !== exp_q[idx]) begin n_fail++; $display("FAIL random_ready_data t%0d beat %0d got %h expected %h", t, idx, prbs_out, exp_q[idx]); end
                n_checks++; if (seq_done !== (out_ready && idx == nr * 4 - 1)) begin n_fail++; $display("FAIL random_ready_seq_done t%0d beat %0d got %b", t, idx, seq_done); end
                if (out_ready) idx++;
                @(negedge clk);
            end
            n_checks++; if (idx !== exp_q.size()) begin n_fail++; $display("FAIL random_ready_timeout t%0d got %0d beats expected %0d", t, idx, exp_q.size()); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] p1;
        logic [31:0] p2;
        for (int v = 0; v < 2; v++) begin
            p1 = $urandom;
            p2 = $urandom;
            out_ready = 1'b1;
            load(p1, 8'd0);
            repeat (3) @(negedge clk);
            out_ready = (v == 1);
            build_model(p2, 1, 3);
            load(p2, 8'd1);
            out_ready = 1'b1;
            for (int i = 0; i < exp_q.size(); i++) begin
                #1;
                n_checks++; if (prbs_out !== exp_q[i]) begin n_fail++; $display("FAIL reload_data v%0d beat %0d got %h expected %h", v, i, prbs_out, exp_q[i]); end
                n_checks++; if (rand_flag !== (i >= 4)) begin n_fail++; $display("FAIL reload_rand_flag v%0d beat %0d got %b", v, i, rand_flag); end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_midrun;
        build_model(32'hDEADBEEF, 2, 4);
        out_ready = 1'b1;
        load(32'hDEADBEEF, 8'd2);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (prbs_out !== 8'h00 || out_valid !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_out got %h/%b expected 00/0", prbs_out, out_valid); end
        n_checks++; if (busy !== 1'b0 || rand_flag !== 1'b0 || seq_done !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_flags got b=%b rf=%b sd=%b expected 0", busy, rand_flag, seq_done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle got %b expected 0", out_valid); end
        load(32'hDEADBEEF, 8'd2);
        for (int i = 0; i < exp_q.size(); i++) begin
            data_valid = (i == 2);
            in_pat     = 32'h12345678;
            n          = 8'd5;
            stop       = (i == 3);
            #1;
            n_checks++; if (prbs_out !== exp_q[i]) begin n_fail++; $display("FAIL seq_ignore_data beat %0d got %h expected %h", i, prbs_out, exp_q[i]); end
            @(negedge clk);
        end
        data_valid = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle got valid=%b busy=%b expected 0 0", out_valid, busy); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stop_stays_idle got %b expected 0", out_valid); end
    endtask

`ifdef PRBS_ERR_INJ_EN
    task automatic test_err_inj;
        logic [31:0] p;
        build_model(32'h1, 0, 8);
        exp_q[2] = exp_q[2] ^ 8'h01;
        out_ready = 1'b1;
        load(32'h1, 8'd0);
        for (int i = 0; i < exp_q.size(); i++) begin
            err_inj = (i == 1);
            #1;
            n_checks++; if (prbs_out !== exp_q[i]) begin n_fail++; $display("FAIL err_inj_data beat %0d got %h expected %h", i, prbs_out, exp_q[i]); end
            @(negedge clk);
        end
        err_inj = 1'b0;
        p = $urandom;
        build_model(p, 1, 4);
        load(p, 8'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            err_inj = (i == 1);
            #1;
            n_checks++; if (prbs_out !== exp_q[i]) begin n_fail++; $display("FAIL err_inj_seq_ignored beat %0d got %h expected %h", i, prbs_out, exp_q[i]); end
            @(negedge clk);
        end
        err_inj = 1'b0;
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_pattern;
        test_n_zero;
        test_period;
        test_backpressure;
        test_back_to_back;
        test_reset_midrun;
`ifdef PRBS_ERR_INJ_EN
        test_err_inj;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
